// File: rtl/phy_tx_arbiter_if.sv
// Byte-stream handshake between the Tx arbiter and the PHY.
interface phy_tx_arbiter_if;
  logic [7:0] oPHY_Data;
  logic       oPHY_Valid;
  logic       iPHY_Ready;

  modport master (output oPHY_Data, output oPHY_Valid, input iPHY_Ready);
  modport slave  (input oPHY_Data, input oPHY_Valid, output iPHY_Ready);
endinterface

// File: rtl/phy_tx_arbiter.sv
// Arbitrates GoodCRC and Tx message requests onto a single PHY byte stream,
// gating on CC line idle and aborting a Tx in favour of a GoodCRC.
module phy_tx_arbiter #(
  parameter int unsigned CC_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        iGoodCRC_Req,
  input  logic [15:0] iGoodCRC_Header,
  input  logic        iTx_Req,
  input  logic [4:0]  iTx_Len,
  input  logic [7:0]  iTx_Data,
  input  logic        CC_Busy,
  input  logic        CC_IDLE,
  phy_tx_arbiter_if.master phy,
  output logic [4:0]  oTx_Byte_Index,
  output logic        oGoodCRC_Done,
  output logic        oTx_Done,
  output logic        oTx_Discarded,
  output logic        oBusy
);

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    WAIT_CC   = 5'b00010,
    SEND_GCRC = 5'b00100,
    SEND_TX   = 5'b01000,
    COMPLETE  = 5'b10000
  } state_e;

  typedef enum logic {OWN_GCRC = 1'b0, OWN_TX = 1'b1} owner_e;

  localparam int unsigned TMO_W = (CC_TIMEOUT < 2) ? 1 : $clog2(CC_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CC_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(CC_TIMEOUT);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [15:0]      hdr_q, hdr_d;
  logic [4:0]       len_q, len_d;
  logic [4:0]       idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             gdone_q, gdone_d;
  logic             tdone_q, tdone_d;
  logic             disc_q, disc_d;

  logic             xfer;

  assign xfer = !CC_Busy && phy.iPHY_Ready;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_GCRC;
      hdr_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      gdone_q <= 1'b0;
      tdone_q <= 1'b0;
      disc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hdr_q   <= hdr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      gdone_q <= gdone_d;
      tdone_q <= tdone_d;
      disc_q  <= disc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hdr_d   = hdr_q;
    len_d   = len_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    gdone_d = 1'b0;
    tdone_d = 1'b0;
    disc_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (iGoodCRC_Req) begin
          state_d = WAIT_CC;
          owner_d = OWN_GCRC;
          hdr_d   = iGoodCRC_Header;
          idx_d   = '0;
          tmo_d   = '0;
        end else if (iTx_Req) begin
          owner_d = OWN_TX;
          len_d   = iTx_Len;
          idx_d   = '0;
          tmo_d   = '0;
          if (iTx_Len == 5'd0) begin
            state_d = COMPLETE;
            disc_d  = 1'b1;
          end else begin
            state_d = WAIT_CC;
          end
        end
      end

      WAIT_CC: begin
        if (owner_q == OWN_TX && iGoodCRC_Req) begin
          // Pending Tx is dropped and the GoodCRC takes over the wait.
          owner_d = OWN_GCRC;
          hdr_d   = iGoodCRC_Header;
          idx_d   = '0;
          tmo_d   = '0;
          disc_d  = 1'b1;
        end else if (CC_IDLE && !CC_Busy) begin
          state_d = (owner_q == OWN_TX) ? SEND_TX : SEND_GCRC;
        end else if (owner_q == OWN_TX && tmo_q == TMO_LAST) begin
          state_d = COMPLETE;
          disc_d  = 1'b1;
        end else if (tmo_q != TMO_MAX) begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      SEND_GCRC: begin
        if (xfer) begin
          if (idx_q == 5'd1) begin
            state_d = COMPLETE;
            gdone_d = 1'b1;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end

      SEND_TX: begin
        if (iGoodCRC_Req) begin
          state_d = WAIT_CC;
          owner_d = OWN_GCRC;
          hdr_d   = iGoodCRC_Header;
          idx_d   = '0;
          tmo_d   = '0;
          disc_d  = 1'b1;
        end else if (xfer) begin
          if (idx_q == len_q - 5'd1) begin
            state_d = COMPLETE;
            tdone_d = 1'b1;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end

      COMPLETE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    phy.oPHY_Valid = 1'b0;
    phy.oPHY_Data  = '0;
    // Valid is withheld on an abort cycle so no byte is handed over.
    if (state_q == SEND_GCRC && !CC_Busy) begin
      phy.oPHY_Valid = 1'b1;
      phy.oPHY_Data  = idx_q[0] ? hdr_q[15:8] : hdr_q[7:0];
    end else if (state_q == SEND_TX && !CC_Busy && !iGoodCRC_Req) begin
      phy.oPHY_Valid = 1'b1;
      phy.oPHY_Data  = iTx_Data;
    end
  end

  assign oTx_Byte_Index = idx_q;
  assign oGoodCRC_Done  = gdone_q;
  assign oTx_Done       = tdone_q;
  assign oTx_Discarded  = disc_q;
  assign oBusy          = (state_q != IDLE);

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Directed bench for phy_tx_arbiter; Tx buffer returns 8'h40 + index.
module tb_phy_tx_arbiter;

  logic        CLK = 1'b0;
  logic        reset;
  logic        gcrc_req;
  logic [15:0] hdr;
  logic        tx_req;
  logic [4:0]  tx_len;
  logic [7:0]  tx_data;
  logic        cc_busy;
  logic        cc_idle;
  logic [4:0]  idx;
  logic        gdone, tdone, disc, busy;

  int errors = 0;
  int checks = 0;

  phy_tx_arbiter_if bus ();

  phy_tx_arbiter #(.CC_TIMEOUT(15)) dut (
    .CLK             (CLK),
    .reset           (reset),
    .iGoodCRC_Req    (gcrc_req),
    .iGoodCRC_Header (hdr),
    .iTx_Req         (tx_req),
    .iTx_Len         (tx_len),
    .iTx_Data        (tx_data),
    .CC_Busy         (cc_busy),
    .CC_IDLE         (cc_idle),
    .phy             (bus.master),
    .oTx_Byte_Index  (idx),
    .oGoodCRC_Done   (gdone),
    .oTx_Done        (tdone),
    .oTx_Discarded   (disc),
    .oBusy           (busy)
  );

  always #5 CLK = ~CLK;

  assign tx_data = 8'h40 + {3'b000, idx};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    reset = 1'b1; gcrc_req = 1'b0; hdr = '0; tx_req = 1'b0; tx_len = '0;
    cc_busy = 1'b0; cc_idle = 1'b1; bus.iPHY_Ready = 1'b1;
    step(); step();
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_valid", 16'(bus.oPHY_Valid), 16'h0);
    chk("rst_data", 16'(bus.oPHY_Data), 16'h0);
    chk("rst_idx", 16'(idx), 16'h0);
    chk("rst_pulses", 16'({gdone, tdone, disc}), 16'h0);
    reset = 1'b0;

    // Plain Tx of 3 bytes
    tx_len = 5'd3; tx_req = 1'b1;
    step(); chk("A_wait_busy", 16'(busy), 16'h1); chk("A_wait_valid", 16'(bus.oPHY_Valid), 16'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("A_valid", 16'(bus.oPHY_Valid), 16'h1);
      chk("A_idx", 16'(idx), 16'(i));
      chk("A_data", 16'(bus.oPHY_Data), 16'(8'h40 + i));
      chk("A_done_early", 16'(tdone), 16'h0);
    end
    step(); chk("A_done", 16'(tdone), 16'h1); chk("A_cmpl_valid", 16'(bus.oPHY_Valid), 16'h0);
    tx_req = 1'b0;
    step(); chk("A_idle_busy", 16'(busy), 16'h0); chk("A_done_clear", 16'(tdone), 16'h0);

    // Simultaneous requests: GoodCRC first, Tx afterwards from IDLE
    hdr = 16'hA1B2; tx_len = 5'd2; gcrc_req = 1'b1; tx_req = 1'b1;
    step(); chk("B_wait_valid", 16'(bus.oPHY_Valid), 16'h0);
    step(); chk("B_byte0_valid", 16'(bus.oPHY_Valid), 16'h1); chk("B_byte0", 16'(bus.oPHY_Data), 16'hB2);
    step(); chk("B_byte1", 16'(bus.oPHY_Data), 16'hA1);
    step(); chk("B_gdone", 16'(gdone), 16'h1); chk("B_no_tdone", 16'(tdone), 16'h0);
    gcrc_req = 1'b0;
    step(); chk("B_idle_between", 16'(busy), 16'h0); chk("B_gdone_clear", 16'(gdone), 16'h0);
    step(); chk("B_tx_wait", 16'(bus.oPHY_Valid), 16'h0);
    step(); chk("B_tx_idx0", 16'(idx), 16'h0); chk("B_tx_d0", 16'(bus.oPHY_Data), 16'h40);
    step(); chk("B_tx_idx1", 16'(idx), 16'h1); chk("B_tx_d1", 16'(bus.oPHY_Data), 16'h41);
    step(); chk("B_tdone", 16'(tdone), 16'h1);
    tx_req = 1'b0;
    step(); chk("B_end_idle", 16'(busy), 16'h0);

    // GoodCRC preempts a Tx after two bytes
    hdr = 16'h1234; tx_len = 5'd5; tx_req = 1'b1;
    step();
    step(); chk("C_idx0", 16'(idx), 16'h0);
    step(); chk("C_idx1", 16'(idx), 16'h1);
    step(); chk("C_idx2", 16'(idx), 16'h2); chk("C_valid2", 16'(bus.oPHY_Valid), 16'h1);
    gcrc_req = 1'b1; #1;
    chk("C_abort_valid", 16'(bus.oPHY_Valid), 16'h0);
    step(); chk("C_disc", 16'(disc), 16'h1); chk("C_idx_clr", 16'(idx), 16'h0);
    chk("C_wait_busy", 16'(busy), 16'h1);
    step(); chk("C_g0", 16'(bus.oPHY_Data), 16'h34); chk("C_disc_clear", 16'(disc), 16'h0);
    step(); chk("C_g1", 16'(bus.oPHY_Data), 16'h12);
    step(); chk("C_gdone", 16'(gdone), 16'h1);
    gcrc_req = 1'b0;
    step(); chk("C_idle", 16'(busy), 16'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("C_re_idx", 16'(idx), 16'(i));
      chk("C_re_data", 16'(bus.oPHY_Data), 16'(8'h40 + i));
    end
    step(); chk("C_tdone", 16'(tdone), 16'h1);
    tx_req = 1'b0;
    step(); chk("C_end_idle", 16'(busy), 16'h0);

    // CC busy: Tx times out after 15 waiting cycles; GoodCRC waits forever
    cc_busy = 1'b1; cc_idle = 1'b0; tx_len = 5'd3; tx_req = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("D_wait_busy", 16'(busy), 16'h1);
      chk("D_no_disc", 16'(disc), 16'h0);
    end
    step(); chk("D_disc", 16'(disc), 16'h1); chk("D_no_valid", 16'(bus.oPHY_Valid), 16'h0);
    tx_req = 1'b0;
    step(); chk("D_idle", 16'({busy, disc}), 16'h0);
    hdr = 16'h5A3C; gcrc_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("D_gcrc_wait", 16'({busy, bus.oPHY_Valid, gdone, disc}), 16'h8);
    end
    cc_busy = 1'b0; cc_idle = 1'b1;
    step(); chk("D_g0", 16'(bus.oPHY_Data), 16'h3C); chk("D_g0_valid", 16'(bus.oPHY_Valid), 16'h1);
    step(); chk("D_g1", 16'(bus.oPHY_Data), 16'h5A);
    step(); chk("D_gdone", 16'(gdone), 16'h1);
    gcrc_req = 1'b0;
    step(); chk("D_end_idle", 16'(busy), 16'h0);

    // PHY ready toggling
    tx_len = 5'd3; tx_req = 1'b1;
    step();
    step(); chk("E_idx0", 16'(idx), 16'h0);
    step(); chk("E_idx1", 16'(idx), 16'h1);
    bus.iPHY_Ready = 1'b0; #1;
    chk("E_valid_notready", 16'(bus.oPHY_Valid), 16'h1);
    step(); chk("E_hold1", 16'(idx), 16'h1);
    bus.iPHY_Ready = 1'b1;
    step(); chk("E_idx2", 16'(idx), 16'h2);
    bus.iPHY_Ready = 1'b0;
    step(); chk("E_hold2", 16'(idx), 16'h2); chk("E_no_done", 16'(tdone), 16'h0);
    bus.iPHY_Ready = 1'b1;
    step(); chk("E_tdone", 16'(tdone), 16'h1);
    tx_req = 1'b0;
    step();

    // CC busy stalls an ongoing Tx without leaving the send state
    tx_len = 5'd2; tx_req = 1'b1;
    step();
    step(); chk("S_idx0", 16'(idx), 16'h0);
    cc_busy = 1'b1; #1;
    chk("S_stall_valid", 16'(bus.oPHY_Valid), 16'h0); chk("S_stall_data", 16'(bus.oPHY_Data), 16'h0);
    step(); chk("S_stall_idx", 16'(idx), 16'h0); chk("S_stall_busy", 16'(busy), 16'h1);
    cc_busy = 1'b0; #1;
    chk("S_resume_valid", 16'(bus.oPHY_Valid), 16'h1);
    step(); chk("S_idx1", 16'(idx), 16'h1);
    step(); chk("S_tdone", 16'(tdone), 16'h1);
    tx_req = 1'b0;
    step();

    // Zero-length Tx is discarded immediately
    tx_len = 5'd0; tx_req = 1'b1;
    step(); chk("Z_disc", 16'(disc), 16'h1); chk("Z_valid", 16'(bus.oPHY_Valid), 16'h0);
    chk("Z_no_tdone", 16'(tdone), 16'h0);
    tx_req = 1'b0;
    step(); chk("Z_idle", 16'({busy, disc}), 16'h0);

    // Reset during SEND_TX
    tx_len = 5'd5; tx_req = 1'b1;
    step(); step(); step();
    chk("F_idx1", 16'(idx), 16'h1);
    reset = 1'b1;
    step();
    chk("F_busy", 16'(busy), 16'h0);
    chk("F_valid", 16'(bus.oPHY_Valid), 16'h0);
    chk("F_data", 16'(bus.oPHY_Data), 16'h0);
    chk("F_idx", 16'(idx), 16'h0);
    chk("F_pulses", 16'({gdone, tdone, disc}), 16'h0);
    tx_req = 1'b0;
    step(); chk("F_pulses2", 16'({gdone, tdone, disc}), 16'h0);
    reset = 1'b0;
    step(); chk("F_after", 16'({busy, gdone, tdone, disc}), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
